gf180mcu_ocd_io__pwr_seq_ctrl: RTL and testbench
================================================

// Module: gf180mcu_ocd_io__pwr_seq_ctrl
// PURPOSE
//  Power-up/down sequencer for the gf180mcu_ocd_io pad ring. Watches core (VDD) and
//  per-segment I/O (DVDD) supply-good flags, then enables pad-driver segments one at a
//  time to limit inrush/SSO. Holds pads isolated until all segments are up; on supply
//  loss it drops everything at once and latches a fault. Sits beside the DVDD/DVSS/VDD/VSS
//  supply cells and drives the ring's segment-enable and pad-hold controls.
// PARAMETERS
//  NSEG        4     number of pad-ring driver segments (>=1)
//  STAGGER     8     cycles between successive segment enable/disable steps (>=1)
//  TIMEOUT     1024  max cycles in WAIT_SUP before fault (>=2)
//  SYNC_STAGES 2     flop stages on the asynchronous supply-good inputs (>=2)
// PORTS
//  CLK        in   1     sequencer clock, all state on rising edge
//  RST        in   1     synchronous reset, active-high
//  PWR_REQ    in   1     level request: 1 = ring powered, 0 = ring off
//  FAULT_CLR  in   1     pulse; clears FAULT when PWR_REQ=0
//  VDD_OK     in   1     core supply good (async)
//  DVDD_OK    in   NSEG  per-segment I/O supply good (async)
//  SEG_EN     out  NSEG  pad-driver segment enables, registered
//  PAD_HOLD   out  1     1 = pads isolated/held, registered
//  READY      out  1     1 = all segments enabled and hold released
//  FAULT      out  1     latched fault flag
//  STATE      out  3     FSM state for debug: OFF=0 WAIT_SUP=1 RAMP_UP=2 ON=3 RAMP_DN=4 FLT=5
// BEHAVIOUR
//  - Clock CLK; reset RST is synchronous and active-high. On reset: STATE=OFF,
//    SEG_EN=0, PAD_HOLD=1, READY=0, FAULT=0, step counter=0, synchronizer flops=0.
//  - VDD_OK/DVDD_OK pass through SYNC_STAGES flops; supply_ok = sync VDD_OK & (&sync DVDD_OK).
//    Input-to-decision latency = SYNC_STAGES cycles.
//  - OFF: PWR_REQ=1 -> WAIT_SUP, cnt=0.
//  - WAIT_SUP: PWR_REQ=0 -> OFF. Else supply_ok=1 -> RAMP_UP; on that same edge
//    SEG_EN[0]<=1, idx=0, cnt=0. Else cnt++; when cnt==TIMEOUT-1 -> FLT.
//  - RAMP_UP: cnt counts 0..STAGGER-1. At cnt==STAGGER-1: if idx<NSEG-1, set SEG_EN[idx+1],
//    idx++, cnt=0; if idx==NSEG-1, PAD_HOLD<=0, READY<=1 -> ON. Segment k enables
//    k*STAGGER cycles after segment 0; READY rises NSEG*STAGGER cycles after SEG_EN[0].
//  - ON: holds outputs. PWR_REQ=0 -> RAMP_DN.
//  - RAMP_DN (from ON or RAMP_UP on PWR_REQ=0): on entry edge PAD_HOLD<=1, READY<=0, cnt=0.
//    Every STAGGER cycles clear the highest set SEG_EN bit (first clear STAGGER cycles after
//    entry). When SEG_EN==0 -> OFF on the next STAGGER boundary. PWR_REQ=1 ignored until OFF.
//  - Supply loss (supply_ok=0) in RAMP_UP, ON or RAMP_DN -> FLT; same edge: SEG_EN<=0,
//    PAD_HOLD<=1, READY<=0, FAULT<=1. Supply loss has priority over PWR_REQ=0.
//  - FLT: outputs held safe. FAULT_CLR=1 & PWR_REQ=0 -> OFF, FAULT<=0. FAULT_CLR with
//    PWR_REQ=1 has no effect.
//  - Invariants: READY=1 only in ON; READY=1 implies PAD_HOLD=0 and SEG_EN all ones;
//    PAD_HOLD=0 only in ON; SEG_EN is always a contiguous mask from bit 0 (thermometer).
//  - RST mid-ramp: next edge forces reset values regardless of state; no partial-step carry.
//  - Counters sized $clog2(max(TIMEOUT,STAGGER)+1); no wrap (cleared on every transition).
// TESTING (NSEG=4, STAGGER=8, TIMEOUT=1024, SYNC_STAGES=2)
//  1. Supplies good, PWR_REQ 0->1 at T -> WAIT_SUP at T+1; SEG_EN 0001,0011,0111,1111 at
//     8-cycle spacing; READY=1, PAD_HOLD=0 exactly 32 cycles after SEG_EN[0].
//  2. From ON, PWR_REQ->0 -> PAD_HOLD=1, READY=0 next edge; SEG_EN 0111,0011,0001,0000 every
//     8 cycles; STATE=OFF 8 cycles after 0000; PWR_REQ pulse during ramp-down ignored.
//  3. DVDD_OK[2] low throughout, PWR_REQ=1 -> FLT exactly 1024 cycles after WAIT_SUP entry,
//     FAULT=1, SEG_EN=0; FAULT_CLR with PWR_REQ=1 keeps FLT; with PWR_REQ=0 -> OFF.
//  4. In ON, drop VDD_OK -> 2 cycles later SEG_EN=0000, PAD_HOLD=1, FAULT=1 in one edge;
//     1-cycle glitch on DVDD_OK[1] also faults (no filtering).
//  5. Assert RST while SEG_EN=0011 mid RAMP_UP -> next edge all outputs at reset values,
//     STATE=OFF; sequence restarts cleanly from PWR_REQ.
//  6. Random PWR_REQ/supply toggling 10k cycles -> invariants never violated.

Source files
------------

// File: rtl/gf180mcu_ocd_io__pwr_seq_ctrl.sv
// Pad-ring power sequencer: synchronizes the supply-good flags, then enables the
// pad-driver segments one at a time, releases pad hold when all are up, ramps
// them back down on request, and drops everything at once on supply loss.
module gf180mcu_ocd_io__pwr_seq_ctrl #(
  parameter int NSEG        = 4,
  parameter int STAGGER     = 8,
  parameter int TIMEOUT     = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            PWR_REQ,
  input  logic            FAULT_CLR,
  input  logic            VDD_OK,
  input  logic [NSEG-1:0] DVDD_OK,
  output logic [NSEG-1:0] SEG_EN,
  output logic            PAD_HOLD,
  output logic            READY,
  output logic            FAULT,
  output logic [2:0]      STATE
);

  localparam int CMAX = (TIMEOUT > STAGGER) ? TIMEOUT : STAGGER;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = (NSEG > 1) ? $clog2(NSEG) : 1;

  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(STAGGER - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NSEG - 1);

  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_WAIT = 3'd1,
    S_UP   = 3'd2,
    S_ON   = 3'd3,
    S_DN   = 3'd4,
    S_FLT  = 3'd5
  } state_t;

  state_t                           state_q, state_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic [IW-1:0]                    idx_q, idx_d;
  logic [NSEG-1:0]                  seg_en_q, seg_en_d;
  logic                             hold_q, hold_d;
  logic                             ready_q, ready_d;
  logic                             fault_q, fault_d;
  logic [SYNC_STAGES-1:0]           vdd_sync_q;
  logic [SYNC_STAGES-1:0][NSEG-1:0] dvdd_sync_q;
  logic                             supply_ok;
  logic                             lose;

  // Synchronizer chains for the asynchronous supply-good flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vdd_sync_q  <= '0;
      dvdd_sync_q <= '0;
    end else begin
      vdd_sync_q  <= {vdd_sync_q[SYNC_STAGES-2:0], VDD_OK};
      dvdd_sync_q <= {dvdd_sync_q[SYNC_STAGES-2:0], DVDD_OK};
    end
  end

  assign supply_ok = vdd_sync_q[SYNC_STAGES-1] & (&dvdd_sync_q[SYNC_STAGES-1]);

  // Next-state and output logic; a supply loss overrides whatever the case chose.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    seg_en_d = seg_en_q;
    hold_d   = hold_q;
    ready_d  = ready_q;
    fault_d  = fault_q;
    lose     = 1'b0;
    unique case (state_q)
      S_OFF: if (PWR_REQ) begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (!PWR_REQ) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end else if (supply_ok) begin
          state_d  = S_UP;
          seg_en_d = NSEG'(1);
          idx_d    = '0;
          cnt_d    = '0;
        end else if (cnt_q == TO_LAST) begin
          lose = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_UP: begin
        if (!supply_ok) begin
          lose = 1'b1;
        end else if (!PWR_REQ) begin
          state_d = S_DN;
          hold_d  = 1'b1;
          ready_d = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == ST_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_ON;
            hold_d  = 1'b0;
            ready_d = 1'b1;
          end else begin
            // Thermometer grow: next segment above the current top.
            seg_en_d = (seg_en_q << 1) | NSEG'(1);
            idx_d    = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ON: begin
        if (!supply_ok) begin
          lose = 1'b1;
        end else if (!PWR_REQ) begin
          state_d = S_DN;
          hold_d  = 1'b1;
          ready_d = 1'b0;
          cnt_d   = '0;
        end
      end
      S_DN: begin
        if (!supply_ok) begin
          lose = 1'b1;
        end else if (cnt_q == ST_LAST) begin
          cnt_d = '0;
          if (seg_en_q == '0) state_d = S_OFF;
          else                seg_en_d = seg_en_q >> 1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FLT: if (FAULT_CLR && !PWR_REQ) begin
        state_d = S_OFF;
        fault_d = 1'b0;
      end
      default: state_d = S_OFF;
    endcase
    if (lose) begin
      state_d  = S_FLT;
      seg_en_d = '0;
      hold_d   = 1'b1;
      ready_d  = 1'b0;
      fault_d  = 1'b1;
      cnt_d    = '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_OFF;
      cnt_q    <= '0;
      idx_q    <= '0;
      seg_en_q <= '0;
      hold_q   <= 1'b1;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      seg_en_q <= seg_en_d;
      hold_q   <= hold_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
    end
  end

  assign SEG_EN   = seg_en_q;
  assign PAD_HOLD = hold_q;
  assign READY    = ready_q;
  assign FAULT    = fault_q;
  assign STATE    = state_q;

endmodule

// File: tb/tb_gf180mcu_ocd_io__pwr_seq_ctrl.sv
// Bench for the pad-ring power sequencer. Directed phases push expected output
// words (tagged, with the cycle they are due) onto a queue as stimulus is driven;
// a negedge monitor pops and compares them. A random phase checks invariants.
module tb_gf180mcu_ocd_io__pwr_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST, PWR_REQ, FAULT_CLR, VDD_OK;
  logic [3:0] DVDD_OK;
  logic [3:0] SEG_EN;
  logic       PAD_HOLD, READY, FAULT;
  logic [2:0] STATE;

  gf180mcu_ocd_io__pwr_seq_ctrl #(
    .NSEG(4), .STAGGER(8), .TIMEOUT(1024), .SYNC_STAGES(2)
  ) dut (
    .CLK(CLK), .RST(RST), .PWR_REQ(PWR_REQ), .FAULT_CLR(FAULT_CLR),
    .VDD_OK(VDD_OK), .DVDD_OK(DVDD_OK), .SEG_EN(SEG_EN), .PAD_HOLD(PAD_HOLD),
    .READY(READY), .FAULT(FAULT), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    string      tag;
    int         at;
    logic [9:0] v;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  wire [9:0] outv = {STATE, FAULT, READY, PAD_HOLD, SEG_EN};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Output word: {state, fault, ready, hold, seg_en}
  function automatic logic [9:0] pk(input logic [2:0] st, input logic f, input logic r,
                                    input logic h, input logic [3:0] seg);
    return {st, f, r, h, seg};
  endfunction

  task automatic expect_in(input int k, input string tag, input logic [9:0] v);
    exp_t e;
    e.tag = tag;
    e.at  = cyc + k;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Scoreboard monitor: compare every entry that has come due.
  always @(negedge CLK) begin : mon
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      e = exp_q.pop_front();
      chk(e.tag, {22'd0, outv}, {22'd0, e.v});
    end
  end

  // From OFF with supplies settled: request power and expect the staggered ramp.
  task automatic powerup();
    PWR_REQ = 1'b1;
    expect_in(1,  "up_wait",      pk(3'd1, 0, 0, 1, 4'h0));
    expect_in(2,  "up_seg0",      pk(3'd2, 0, 0, 1, 4'h1));
    expect_in(9,  "up_seg0_last", pk(3'd2, 0, 0, 1, 4'h1));
    expect_in(10, "up_seg1",      pk(3'd2, 0, 0, 1, 4'h3));
    expect_in(18, "up_seg2",      pk(3'd2, 0, 0, 1, 4'h7));
    expect_in(26, "up_seg3",      pk(3'd2, 0, 0, 1, 4'hF));
    expect_in(33, "up_pre_ready", pk(3'd2, 0, 0, 1, 4'hF));
    expect_in(34, "up_ready",     pk(3'd3, 0, 1, 0, 4'hF));
    tick(36);
  endtask

  // From ON: drop request, expect staggered ramp-down; a request pulse mid-way is ignored.
  task automatic powerdown();
    PWR_REQ = 1'b0;
    expect_in(1,  "dn_entry",   pk(3'd4, 0, 0, 1, 4'hF));
    expect_in(8,  "dn_pre_7",   pk(3'd4, 0, 0, 1, 4'hF));
    expect_in(9,  "dn_7",       pk(3'd4, 0, 0, 1, 4'h7));
    expect_in(17, "dn_3",       pk(3'd4, 0, 0, 1, 4'h3));
    expect_in(25, "dn_1",       pk(3'd4, 0, 0, 1, 4'h1));
    expect_in(33, "dn_0",       pk(3'd4, 0, 0, 1, 4'h0));
    expect_in(40, "dn_pre_off", pk(3'd4, 0, 0, 1, 4'h0));
    expect_in(41, "dn_off",     pk(3'd0, 0, 0, 1, 4'h0));
    expect_in(45, "dn_stay",    pk(3'd0, 0, 0, 1, 4'h0));
    tick(10);
    PWR_REQ = 1'b1;
    tick(1);
    PWR_REQ = 1'b0;
    tick(36);
  endtask

  // Leave FLT via FAULT_CLR with request low, then let the synchronizers settle.
  task automatic clear_fault();
    PWR_REQ   = 1'b0;
    FAULT_CLR = 1'b1;
    expect_in(1, "clr_off", pk(3'd0, 0, 0, 1, 4'h0));
    tick(1);
    FAULT_CLR = 1'b0;
    tick(4);
  endtask

  initial begin
    RST = 1'b1; PWR_REQ = 1'b0; FAULT_CLR = 1'b0; VDD_OK = 1'b1; DVDD_OK = 4'hF;
    tick(3);
    chk("reset_outs", {22'd0, outv}, {22'd0, pk(3'd0, 0, 0, 1, 4'h0)});
    RST = 1'b0;
    tick(3);

    // Normal power-up and power-down.
    powerup();
    powerdown();

    // Missing DVDD on segment 2: WAIT_SUP times out.
    DVDD_OK = 4'b1011;
    tick(4);
    PWR_REQ = 1'b1;
    expect_in(1,    "to_wait", pk(3'd1, 0, 0, 1, 4'h0));
    expect_in(1024, "to_pre",  pk(3'd1, 0, 0, 1, 4'h0));
    expect_in(1025, "to_flt",  pk(3'd5, 1, 0, 1, 4'h0));
    tick(1027);
    FAULT_CLR = 1'b1;
    expect_in(1, "clr_ignored", pk(3'd5, 1, 0, 1, 4'h0));
    tick(1);
    FAULT_CLR = 1'b0;
    tick(2);
    DVDD_OK = 4'hF;
    clear_fault();

    // VDD loss while ON: two synchronizer edges, then one-edge shutdown.
    powerup();
    VDD_OK = 1'b0;
    expect_in(2, "vdd_pre", pk(3'd3, 0, 1, 0, 4'hF));
    expect_in(3, "vdd_flt", pk(3'd5, 1, 0, 1, 4'h0));
    tick(4);
    VDD_OK = 1'b1;
    clear_fault();

    // One-cycle glitch on DVDD_OK[1] is not filtered.
    powerup();
    DVDD_OK = 4'b1101;
    expect_in(3, "glitch_flt", pk(3'd5, 1, 0, 1, 4'h0));
    tick(1);
    DVDD_OK = 4'hF;
    tick(3);
    clear_fault();

    // Reset in the middle of RAMP_UP, then a clean restart.
    PWR_REQ = 1'b1;
    expect_in(10, "rst_pre", pk(3'd2, 0, 0, 1, 4'h3));
    tick(12);
    RST = 1'b1;
    expect_in(1, "rst_mid", pk(3'd0, 0, 0, 1, 4'h0));
    tick(1);
    RST = 1'b0;
    PWR_REQ = 1'b0;
    tick(4);
    powerup();
    powerdown();

    // Random toggling with invariant checks every cycle.
    for (int i = 0; i < 10000; i++) begin
      tick(1);
      chk("inv_ready", (READY ? (STATE == 3'd3 && !PAD_HOLD && SEG_EN == 4'hF) : 1'b1), 1);
      chk("inv_hold",  (!PAD_HOLD ? (STATE == 3'd3) : 1'b1), 1);
      chk("inv_therm", ((SEG_EN & (SEG_EN + 4'd1)) == 4'd0), 1);
      if ($urandom_range(149, 0) == 0) PWR_REQ = ~PWR_REQ;
      VDD_OK    = ($urandom_range(499, 0) != 0);
      DVDD_OK   = 4'hF;
      if ($urandom_range(299, 0) == 0) DVDD_OK[$urandom_range(3, 0)] = 1'b0;
      FAULT_CLR = ($urandom_range(39, 0) == 0);
    end

    // Wind down to OFF from wherever the random phase left the sequencer.
    PWR_REQ = 1'b0; VDD_OK = 1'b1; DVDD_OK = 4'hF; FAULT_CLR = 1'b1;
    tick(60);
    FAULT_CLR = 1'b0;
    tick(2);
    chk("final_off", {29'd0, STATE}, 32'd0);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
